// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Runs a fixed-latency busy countdown and commits HI/LO on its last cycle.
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [1:0]  op_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    // Arithmetic datapath, driven only by the latched operands
    logic        is_div;
    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        div_by_zero;

    always_comb begin
        is_div    = op_reg[1];
        is_signed = ~op_reg[0];

        // Low 64 bits of the product of extended operands equal the
        // signed or unsigned 64-bit product depending on the extension.
        a_ext   = is_signed ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
        b_ext   = is_signed ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
        product = a_ext * b_ext;

        // Magnitude divide; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
        a_neg  = is_signed & a_reg[31];
        b_neg  = is_signed & b_reg[31];
        a_mag  = a_neg ? (~a_reg + 32'd1) : a_reg;
        b_mag  = b_neg ? (~b_reg + 32'd1) : b_reg;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;

        quotient  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        remainder = a_neg ? (~r_mag + 32'd1) : r_mag;

        div_by_zero = is_div && (b_reg == 32'd0);

        if (is_div) begin
            result_hi = remainder;
            result_lo = quotient;
        end else begin
            result_hi = product[63:32];
            result_lo = product[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            op_reg    <= 2'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                a_reg     <= a;
                                b_reg     <= b;
                                op_reg    <= op[1:0];
                                count_reg <= MUL_LOAD;
                                state_reg <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_reg     <= a;
                                b_reg     <= b;
                                op_reg    <= op[1:0];
                                count_reg <= DIV_LOAD;
                                state_reg <= RUN;
                            end
                            OP_MTHI: hi_reg <= a;
                            OP_MTLO: lo_reg <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Any start seen here is ignored: the stall keeps it from happening.
                    count_reg <= count_reg - 4'd1;
                    if (count_reg <= 4'd1) begin
                        count_reg <= 4'd0;
                        state_reg <= IDLE;
                        if (!div_by_zero) begin
                            hi_reg <= result_hi;
                            lo_reg <= result_lo;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy  = (state_reg == RUN);
    assign stall = d_use && (busy || (start && (op <= OP_DIVU)));
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule
